// File: rtl/rv_mc_ctl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller (rv_mc_ctl):
// state enum, opcode/funct3 patterns, trap cause codes and datapath select values.
package rv_ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_LW_MEM,
    S_LW_WB,
    S_SW_MEM,
    S_RTYPE_ALU,
    S_ITYPE_ALU,
    S_ALU_WB,
    S_BR_EXEC,
    S_JAL_EXEC,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  localparam logic       PC_INC    = 1'b0;
  localparam logic       PC_ALU    = 1'b1;
  localparam logic [1:0] WB_PC     = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;
  localparam logic [1:0] IMM_I     = 2'd0;
  localparam logic [1:0] IMM_S     = 2'd1;
  localparam logic [1:0] IMM_B     = 2'd2;
  localparam logic [1:0] IMM_J     = 2'd3;
  localparam logic [1:0] ALUA_REG  = 2'd0;
  localparam logic [1:0] ALUA_PCC  = 2'd1;
  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_IMM  = 2'd1;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  // Successor of DECODE; anything not recognised here is an illegal instruction.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
    if ((op == OP_LOAD || op == OP_STORE) && f3 == F3_W) return S_MEM_ADDR;
    if (op == OP_RTYPE)                                  return S_RTYPE_ALU;
    if (op == OP_IALU)                                   return S_ITYPE_ALU;
    if (op == OP_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE)) return S_BR_EXEC;
    if (op == OP_JAL)                                    return S_JAL_EXEC;
    return S_TRAP;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_LW_MEM) || (s == S_SW_MEM);
  endfunction

endpackage

// File: rtl/rv_mc_ctl_if.sv
// Control-plane bundle between rv_mc_ctl (master) and the IR/datapath/memory side (slave).
interface rv_mc_ctl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ack;
  logic        mem_req;
  logic        memrw;
  logic        pcsourse;
  logic        pcwrite;
  logic        pccen;
  logic        irwrite;
  logic        mdrwrite;
  logic        regwen;
  logic [1:0]  wbsel;
  logic [1:0]  immsel;
  logic [1:0]  asel;
  logic [1:0]  bsel;
  logic [3:0]  alusel;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    input  instr, zero, mem_ack,
    output mem_req, memrw, pcsourse, pcwrite, pccen, irwrite, mdrwrite, regwen,
           wbsel, immsel, asel, bsel, alusel, trap, trap_cause
  );

  modport slave (
    output instr, zero, mem_ack,
    input  mem_req, memrw, pcsourse, pcwrite, pccen, irwrite, mdrwrite, regwen,
           wbsel, immsel, asel, bsel, alusel, trap, trap_cause
  );
endinterface

// File: rtl/rv_mc_ctl_mem_wait.sv
// rv_mem_wait: counts unacknowledged memory request cycles and flags a timeout
// when the count reaches MAX_WAIT without an ack (MAX_WAIT = 0 disables it).
module rv_mem_wait #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic clr,
  output logic timeout
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (req && !ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An ack arriving on the limit cycle still completes the access.
  assign timeout = (MAX_WAIT != 0) && req && !ack && (r_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/rv_mc_ctl.sv
// rv_mc_ctl: multicycle RISC-V control FSM with memory handshake, wait timeout and
// sticky trap. Define RV_CTL_PERF_EN to add the CNT_W-bit retired-instruction counter.
module rv_mc_ctl
  import rv_ctl_pkg::*;
#(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
`ifdef RV_CTL_PERF_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  rv_mc_ctl_if.master bus
`ifdef RV_CTL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cause;
  logic [1:0]  w_cause_nxt;
  logic        w_req;
  logic        w_clr;
  logic        w_timeout;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_b30;
  logic        w_unused;

  assign w_op     = bus.instr[6:0];
  assign w_f3     = bus.instr[14:12];
  assign w_b30    = bus.instr[30];
  assign w_unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  assign w_req = is_mem_state(r_state);
  assign w_clr = is_mem_state(w_next) && (w_next != r_state);

  rv_mem_wait #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .req    (w_req),
    .ack    (bus.mem_ack),
    .clr    (w_clr),
    .timeout(w_timeout)
  );

  always_comb begin
    w_next      = r_state;
    w_cause_nxt = TC_NONE;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ack)    w_next = S_DECODE;
        else if (w_timeout) begin w_next = S_TRAP; w_cause_nxt = TC_TIMEOUT; end
      end
      S_DECODE: begin
        w_next = decode_next(w_op, w_f3);
        if (w_next == S_TRAP) w_cause_nxt = TC_ILLEGAL;
      end
      S_MEM_ADDR: w_next = (w_op == OP_STORE) ? S_SW_MEM : S_LW_MEM;
      S_LW_MEM: begin
        if (bus.mem_ack)    w_next = S_LW_WB;
        else if (w_timeout) begin w_next = S_TRAP; w_cause_nxt = TC_TIMEOUT; end
      end
      S_SW_MEM: begin
        if (bus.mem_ack)    w_next = S_FETCH;
        else if (w_timeout) begin w_next = S_TRAP; w_cause_nxt = TC_TIMEOUT; end
      end
      S_LW_WB, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC: w_next = S_FETCH;
      S_RTYPE_ALU, S_ITYPE_ALU:                 w_next = S_ALU_WB;
      S_TRAP:                                   w_next = S_TRAP;
      default:                                  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cause <= TC_NONE;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP && r_state != S_TRAP) r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    bus.mem_req  = w_req;
    bus.memrw    = 1'b0;
    bus.pcsourse = PC_INC;
    bus.pcwrite  = 1'b0;
    bus.pccen    = 1'b0;
    bus.irwrite  = 1'b0;
    bus.mdrwrite = 1'b0;
    bus.regwen   = 1'b0;
    bus.wbsel    = WB_PC;
    bus.immsel   = IMM_B;
    bus.asel     = ALUA_REG;
    bus.bsel     = ALUB_REG;
    bus.alusel   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        bus.irwrite = bus.mem_ack;
        bus.pcwrite = bus.mem_ack;
        bus.pccen   = bus.mem_ack;
      end
      // Branch target is computed here so BR_EXEC only needs the compare.
      S_DECODE: begin
        bus.asel   = ALUA_PCC;
        bus.bsel   = ALUB_IMM;
        bus.immsel = IMM_B;
      end
      S_MEM_ADDR: begin
        bus.bsel   = ALUB_IMM;
        bus.immsel = (w_op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_LW_MEM: bus.mdrwrite = bus.mem_ack;
      S_LW_WB: begin
        bus.wbsel  = WB_MDR;
        bus.regwen = 1'b1;
      end
      S_SW_MEM:    bus.memrw = 1'b1;
      S_RTYPE_ALU: bus.alusel = {w_f3, w_b30};
      S_ITYPE_ALU: begin
        bus.bsel   = ALUB_IMM;
        bus.immsel = IMM_I;
        bus.alusel = (w_f3 == F3_SR) ? {w_f3, w_b30} : {w_f3, 1'b0};
      end
      S_ALU_WB: begin
        bus.wbsel  = WB_ALUOUT;
        bus.regwen = 1'b1;
      end
      S_BR_EXEC: begin
        bus.alusel   = ALU_SUB;
        bus.pcsourse = PC_ALU;
        bus.pcwrite  = (w_f3 == F3_BEQ) ? bus.zero : !bus.zero;
      end
      S_JAL_EXEC: begin
        bus.asel     = ALUA_PCC;
        bus.bsel     = ALUB_IMM;
        bus.immsel   = IMM_J;
        bus.pcsourse = PC_ALU;
        bus.pcwrite  = 1'b1;
        bus.regwen   = 1'b1;
        bus.wbsel    = WB_PC;
      end
      default: ;
    endcase
  end

  assign bus.trap       = (r_state == S_TRAP);
  assign bus.trap_cause = r_cause;

`ifdef RV_CTL_PERF_EN
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  assign w_retire = (r_state == S_LW_WB) || (r_state == S_ALU_WB) ||
                    (r_state == S_BR_EXEC) || (r_state == S_JAL_EXEC) ||
                    ((r_state == S_SW_MEM) && bus.mem_ack);

  always_ff @(posedge clk) begin
    if (rst)           r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 1'b1;
  end

  assign retired = r_retired;
`endif

endmodule

// File: doc/rv_mc_ctl.md
# rv_mc_ctl

Parametrised successor of the multicycle RISC-V control plane. Drives the same datapath select and enable set as the current controller, and adds four things: a variable-latency memory handshake (`mem_req`/`mem_ack`), a wait-timeout trap, I-type ALU and BNE support, and a sticky trap state for illegal opcodes. It sits between the instruction register/datapath and the unified memory port.

## Interface
- `WAIT_W`, default 4: width of the memory wait counter.
- `MAX_WAIT`, default 15: number of unacked request cycles tolerated before a timeout trap; 0 disables the timeout. Must fit in `WAIT_W`.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: IR contents.
- `zero` in 1: ALU zero flag.
- `mem_ack` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `memrw` out 1: 1 = write, qualified by `mem_req`.
- `pcsourse` out 1, `pcwrite` out 1, `pccen` out 1, `irwrite` out 1, `mdrwrite` out 1, `regwen` out 1.
- `wbsel` out 2, `immsel` out 2, `asel` out 2, `bsel` out 2, `alusel` out 4.
- `trap` out 1: sticky trap indication.
- `trap_cause` out 2: 0 none, 1 illegal opcode, 2 memory timeout.
- `retired` out `CNT_W`: retired-instruction count (only with `RV_CTL_PERF_EN`).

## Operation
- Decoding uses `{instr[6:0], instr[14:12]}`:
  - LW: 0000011/010. SW: 0100011/010. R-type: 0110011/xxx. I-ALU: 0010011/xxx.
  - BEQ: 1100011/000. BNE: 1100011/001. JAL: 1101111/xxx.
- Every output is combinational from state plus inputs. Defaults in every state: PC_INC, WB_PC, IMM_B, ALUA_REG, ALUB_REG, ALU_ADD, all enables 0.
- States and transitions:
  - **FETCH**: `mem_req`=1. On `mem_ack`: `irwrite`=`pcwrite`=`pccen`=1, go to DECODE. Otherwise stay.
  - **DECODE**: `asel`=ALUA_PCC, `bsel`=ALUB_IMM, `immsel`=IMM_B (precomputes the branch target).
    - LW or SW goes to MEM_ADDR.
    - R-type goes to RTYPE_ALU.
    - I-ALU goes to ITYPE_ALU.
    - BEQ or BNE goes to BR_EXEC.
    - JAL goes to JAL_EXEC.
    - Anything else goes to TRAP with cause 1.
  - **MEM_ADDR**: `bsel`=ALUB_IMM; `immsel`=IMM_I for LW, IMM_S for SW. LW goes to LW_MEM, SW goes to SW_MEM.
  - **LW_MEM**: `mem_req`=1, `mdrwrite`=`mem_ack`. On ack go to LW_WB.
  - **LW_WB**: `wbsel`=WB_MDR, `regwen`=1, go to FETCH.
  - **SW_MEM**: `mem_req`=1, `memrw`=1. On ack go to FETCH.
  - **RTYPE_ALU**: `alusel`={instr[14:12], instr[30]}, go to ALU_WB.
  - **ITYPE_ALU**: `bsel`=ALUB_IMM, `immsel`=IMM_I. `alusel`={funct3, instr[30]} when funct3=101, else {funct3, 0}. Go to ALU_WB.
  - **ALU_WB**: `wbsel`=WB_ALUOUT, `regwen`=1, go to FETCH.
  - **BR_EXEC**: ALU_SUB, `pcsourse`=PC_ALU. `pcwrite`=`zero` for BEQ, `pcwrite`=!`zero` for BNE. Go to FETCH.
  - **JAL_EXEC**: ALUA_PCC, ALUB_IMM, IMM_J, PC_ALU, `pcwrite`=1, `regwen`=1, WB_PC. Go to FETCH.
  - **TRAP**: all enables 0, `mem_req`=0, `trap`=1. Stays in TRAP until `rst`.
- Wait counter:
  - Cleared on entry to any memory state (FETCH, LW_MEM, SW_MEM).
  - Increments each cycle `mem_req`=1 and `mem_ack`=0.
  - When it equals `MAX_WAIT` with no ack and `MAX_WAIT`≠0, the next state is TRAP with cause 2.
  - Ack in the same cycle as the limit is reached wins; no trap.

## Timing
- `rst` is sampled on the rising edge. Next state after reset is FETCH, with the wait counter, `trap_cause` and `retired` all at 0.
- Outputs in the reset-following cycle are the FETCH outputs: `mem_req`=1, all other enables 0 until ack.
- Minimum latency with zero memory wait states:
  - LW: 5 cycles.
  - SW: 4 cycles.
  - R-type and I-ALU: 4 cycles.
  - BEQ, BNE and JAL: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- `mem_req` stays high continuously until the ack cycle and drops the cycle after ack.
- A `rst` asserted mid-request abandons the access; `mem_req` is still high during the reset cycle.

## Configuration
- `RV_CTL_PERF_EN` defined:
  - `retired` increments (wrapping at 2^CNT_W) on the final cycle of each instruction: LW_WB, acked SW_MEM, ALU_WB, BR_EXEC, JAL_EXEC.
  - It does not increment in TRAP.
- `RV_CTL_PERF_EN` undefined: the `retired` port and its counter are absent.

## Structure
- Package `rv_ctl_pkg` holds:
  - The state enum.
  - Opcode/funct3 patterns.
  - `trap_cause` codes.
  - Select encodings:
    - PC_INC=0, PC_ALU=1.
    - WB_PC=0, WB_ALUOUT=1, WB_MDR=2.
    - IMM_I=0, IMM_S=1, IMM_B=2, IMM_J=3.
    - ALUA_REG=0, ALUA_PCC=1.
    - ALUB_REG=0, ALUB_IMM=1.
    - ALU_ADD=0000, ALU_SUB=0001.
- Sub-module `rv_mem_wait` holds the wait counter and timeout compare: inputs `req`/`ack`/`clr`, output `timeout`.

## Test plan
- ADDI x1,x0,5 with ack on the first request cycle: FETCH, DECODE, ITYPE_ALU, ALU_WB. `regwen`=1 in cycle 4, `alusel`=0000, `immsel`=IMM_I.
- LW with `mem_ack` delayed 3 cycles on the data access: `mem_req` high for 4 cycles in LW_MEM, `mdrwrite` pulses once on the ack cycle, `regwen` comes 1 cycle later.
- BNE with `zero`=0: `pcwrite`=1 in BR_EXEC. With `zero`=1: `pcwrite`=0. BEQ gives the inverse results.
- Opcode 1110011 (unimplemented): TRAP after DECODE, `trap`=1, `trap_cause`=1, `mem_req`=0 held for 20 cycles. `rst` then restarts at FETCH.
- `mem_ack` never asserted in FETCH, `MAX_WAIT`=15: TRAP entered after 16 request cycles with `trap_cause`=2. Ack on cycle 16 instead gives DECODE with no trap.
- With `RV_CTL_PERF_EN` and `CNT_W`=4: run 17 instructions and expect `retired`=1 (wrap).
